// File: rtl/clock_step_scheduler.sv
// Run/halt/single-step controller: issues a one-cycle cpu_en pulse every limit_q+1 clkin cycles
// while running, or one pulse per step_req rising edge while halted. Optional macro: CYCLE_COUNT_EN.
module clock_step_scheduler #(
    parameter int DIV_W         = 32,
    parameter int DEFAULT_LIMIT = 10,
    parameter int CNT_W         = 32
) (
    input  logic             clkin,
    input  logic             clr_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_limit,
    output logic             cpu_en,
    output logic             running,
    output logic             busy,
    output logic [DIV_W-1:0] limit_q,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] cnt, cnt_nx, limit_nx;
    logic             en_nx;
    logic             step_q;
    logic             step_rise;

    assign step_rise = step_req & ~step_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        en_nx    = 1'b0;
        limit_nx = limit_q;
        case (state)
            HALT: begin
                cnt_nx = '0;
                // The new limit lands on the same edge that starts a run/step, so it governs it.
                if (div_load) limit_nx = div_limit;
                if (!halt_req) begin
                    if (step_rise)    state_nx = STEP;
                    else if (run_req) state_nx = RUN;
                end
            end
            RUN, STEP: begin
                if (halt_req) begin
                    state_nx = HALT;
                    cnt_nx   = '0;
                end else if (cnt == limit_q) begin
                    cnt_nx = '0;
                    en_nx  = 1'b1;
                    if (state == STEP) state_nx = HALT;
                end else begin
                    cnt_nx = cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nx = HALT;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            state   <= HALT;
            cnt     <= '0;
            cpu_en  <= 1'b0;
            running <= 1'b0;
            busy    <= 1'b0;
            limit_q <= DIV_W'(DEFAULT_LIMIT);
            // step_q starts high so a step_req held through reset is not seen as an edge.
            step_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            state   <= state_nx;
            cnt     <= cnt_nx;
            cpu_en  <= en_nx;
            running <= (state_nx == RUN);
            busy    <= (state_nx != HALT);
            limit_q <= limit_nx;
            step_q  <= step_req;
        end
    end

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n)      cycle_count <= '0;
        else if (cpu_en) cycle_count <= cycle_count + CNT_W'(1);
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clock_step_scheduler.sv
// Self-checking bench for clock_step_scheduler: vector table, hand-written corner sequences,
// and randomized stimulus against a countdown-based reference model.
module tb_clock_step_scheduler;

    localparam int DIV_W = 32;
    localparam int CNT_W = 32;

    logic             clkin = 1'b0;
    logic             clr_n;
    logic             run_req, halt_req, step_req, div_load;
    logic [DIV_W-1:0] div_limit;
    logic             cpu_en, running, busy;
    logic [DIV_W-1:0] limit_q;
    logic [CNT_W-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    clock_step_scheduler #(.DIV_W(DIV_W), .DEFAULT_LIMIT(10), .CNT_W(CNT_W)) dut (
        .clkin(clkin), .clr_n(clr_n), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .div_load(div_load), .div_limit(div_limit),
        .cpu_en(cpu_en), .running(running), .busy(busy), .limit_q(limit_q),
        .cycle_count(cycle_count)
    );

    always #5 clkin = ~clkin;

    // Reference model: a countdown of cycles remaining until the next pulse.
    int          m_mode;       // 0 halted, 1 running, 2 stepping
    longint      m_remain;
    logic [31:0] m_limit;
    logic        m_stepq, m_en;
    logic [31:0] m_pulses;

    task automatic model_reset();
        m_mode = 0; m_remain = 0; m_limit = 32'd10;
        m_stepq = 1'b1; m_en = 1'b0; m_pulses = '0;
    endtask

    task automatic model_edge();
        logic rise;
        rise = step_req & ~m_stepq;
        m_stepq = step_req;
        if (m_en) m_pulses = m_pulses + 32'd1;
        if (m_mode == 0) begin
            m_en = 1'b0;
            if (div_load) m_limit = div_limit;
            if (!halt_req && (rise || run_req)) begin
                m_mode   = rise ? 2 : 1;
                m_remain = longint'(m_limit) + 1;
            end
        end else if (halt_req) begin
            m_mode = 0; m_en = 1'b0;
        end else begin
            m_remain--;
            m_en = (m_remain == 0);
            if (m_en) begin
                if (m_mode == 1) m_remain = longint'(m_limit) + 1;
                else             m_mode = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef CYCLE_COUNT_EN
        return m_pulses;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cpu_en"},      64'(cpu_en),      64'(m_en));
        check({tag, ".running"},     64'(running),     64'(m_mode == 1));
        check({tag, ".busy"},        64'(busy),        64'(m_mode != 0));
        check({tag, ".limit_q"},     64'(limit_q),     64'(m_limit));
        check({tag, ".cycle_count"}, 64'(cycle_count), 64'(exp_count()));
    endtask

    // Drive inputs, advance one edge in DUT and model, then settle away from the edge.
    task automatic cycle(input logic r, input logic h, input logic s, input logic l,
                         input logic [31:0] lim);
        run_req = r; halt_req = h; step_req = s; div_load = l; div_limit = lim;
        model_edge();
        @(posedge clkin);
        #1;
    endtask

    task automatic idle(input logic s);
        cycle(1'b0, 1'b0, s, 1'b0, 32'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        clr_n = 1'b0;
        #2;
        model_reset();
        check("reset.cpu_en",      64'(cpu_en),      64'd0);
        check("reset.running",     64'(running),     64'd0);
        check("reset.busy",        64'(busy),        64'd0);
        check("reset.limit_q",     64'(limit_q),     64'd10);
        check("reset.cycle_count", 64'(cycle_count), 64'd0);
        @(negedge clkin);
        clr_n = 1'b1;
    endtask

    typedef struct {
        logic        run, halt, step, load;
        logic [31:0] lim;
        logic        en, rn, bz;
        logic [31:0] exp_lim;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int r, input int h, input int s, input int l, input int lim,
                           input int en, input int rn, input int bz, input int el);
        vec_t v;
        v.run = r[0]; v.halt = h[0]; v.step = s[0]; v.load = l[0]; v.lim = lim;
        v.en = en[0]; v.rn = rn[0]; v.bz = bz[0]; v.exp_lim = el;
        vq.push_back(v);
    endtask

    initial begin
        clr_n = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        div_load = 1'b0; div_limit = '0;
        model_reset();
        #3;

        // ---- Vector table: run(limit 2), step(limit 2), step with load 0, run at limit 0
        //        run h  s  l  lim  en rn bz lim
        add_vec(0, 0, 0, 1, 2,   0, 0, 0, 2);
        add_vec(1, 0, 0, 0, 0,   0, 1, 1, 2);
        add_vec(0, 0, 0, 0, 0,   0, 1, 1, 2);
        add_vec(0, 0, 0, 0, 0,   0, 1, 1, 2);
        add_vec(0, 0, 0, 0, 0,   1, 1, 1, 2);
        add_vec(0, 0, 0, 0, 0,   0, 1, 1, 2);
        add_vec(0, 0, 0, 1, 5,   0, 1, 1, 2);
        add_vec(0, 0, 0, 0, 0,   1, 1, 1, 2);
        add_vec(0, 1, 0, 0, 0,   0, 0, 0, 2);
        add_vec(0, 0, 1, 0, 0,   0, 0, 1, 2);
        add_vec(0, 0, 1, 0, 0,   0, 0, 1, 2);
        add_vec(0, 0, 1, 0, 0,   0, 0, 1, 2);
        add_vec(0, 0, 1, 0, 0,   1, 0, 0, 2);
        add_vec(0, 0, 1, 0, 0,   0, 0, 0, 2);
        add_vec(0, 0, 0, 0, 0,   0, 0, 0, 2);
        add_vec(0, 0, 1, 1, 0,   0, 0, 1, 0);
        add_vec(0, 0, 1, 0, 0,   1, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0,   0, 1, 1, 0);
        add_vec(0, 0, 0, 0, 0,   1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 0,   1, 1, 1, 0);
        add_vec(0, 1, 0, 0, 0,   0, 0, 0, 0);

        do_reset();
        foreach (vq[i]) begin
            cycle(vq[i].run, vq[i].halt, vq[i].step, vq[i].load, vq[i].lim);
            check($sformatf("vec%0d.cpu_en", i),  64'(cpu_en),  64'(vq[i].en));
            check($sformatf("vec%0d.running", i), 64'(running), 64'(vq[i].rn));
            check($sformatf("vec%0d.busy", i),    64'(busy),    64'(vq[i].bz));
            check($sformatf("vec%0d.limit_q", i), 64'(limit_q), 64'(vq[i].exp_lim));
        end
        check("vec.cycle_count", 64'(cycle_count), 64'(exp_count()));

        // ---- Default limit 10: pulses after edges 11, 22, 33
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 33; k++) begin
            idle(1'b0);
            check($sformatf("div10.k%0d.cpu_en", k), 64'(cpu_en), 64'((k % 11) == 0));
            if (k % 11 == 0) check($sformatf("div10.k%0d.running", k), 64'(running), 64'd1);
        end

        // ---- Halt on the edge where the pulse would fire, then full-period restart (limit 3)
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 3; k++) idle(1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("halt_at_limit.cpu_en", 64'(cpu_en), 64'd0);
        check("halt_at_limit.busy",   64'(busy),   64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b0);
            check($sformatf("restart.k%0d.cpu_en", k), 64'(cpu_en), 64'(k == 4));
        end

        // ---- div_load ignored while running; then halt, load 0, run: pulse every cycle
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        check("load_in_run.limit_q", 64'(limit_q), 64'd3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        check("load_in_halt.limit_q", 64'(limit_q), 64'd0);

        // ---- Limit 0 run for 20 pulses, then halt; pulse counter reaches 20
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            idle(1'b0);
            check($sformatf("lim0.k%0d.cpu_en", k), 64'(cpu_en), 64'd1);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1'b0);
`ifdef CYCLE_COUNT_EN
        check("count20.cycle_count", 64'(cycle_count), 64'd20);
`else
        check("count20.cycle_count", 64'(cycle_count), 64'd0);
`endif

        // ---- Reset while running clears everything at once
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pre_reset.running", 64'(running), 64'd1);
        do_reset();

        // ---- step_req held through reset release is not an edge
        step_req = 1'b1;
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("held_step.running", 64'(running), 64'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check($sformatf("held_step.k%0d.busy", k), 64'(busy), 64'd0);
        end
        idle(1'b0);
        idle(1'b1);
        check("new_step.busy",    64'(busy),    64'd1);
        check("new_step.running", 64'(running), 64'd0);
        for (int k = 1; k <= 11; k++) idle(1'b1);
        check("new_step.pulse", 64'(cpu_en), 64'd1);
        check("new_step.done",  64'(busy),   64'd0);

        // ---- Randomized stimulus against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 2) == 0) ? ~step_req : step_req,
                      ($urandom_range(0, 5) == 0), 32'($urandom_range(0, 5)));
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
